icache_refill: RTL and testbench

ICACHE_REFILL -- requirements
Module: icache_refill

---
 rtl/icache_refill.sv | 77 +++++++
 tb/tb_icache_refill.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/icache_refill.sv
// icache_refill: refills one instruction-cache line over a shared byte-wide RAM port,
// issuing one byte address per granted cycle and assembling returned bytes into a line.
module icache_refill #(
    parameter int BLOCK_WIDTH = 4,
    parameter int BLOCK_SIZE  = 2 ** BLOCK_WIDTH
) (
    input  logic                    clkIn,
    input  logic                    resetIn,
    input  logic                    readyIn,
    input  logic                    flushIn,
    input  logic                    missIn,
    input  logic [31:0]             missAddrIn,
    output logic                    memReqOut,
    input  logic                    memGrantIn,
    output logic [31:0]             memAddrOut,
    input  logic [7:0]              memByteIn,
    output logic                    memDataValid,
    output logic [31:BLOCK_WIDTH]   memAddr,
    output logic [BLOCK_SIZE*8-1:0] memDataOut,
    output logic                    busy
);
    typedef enum logic [1:0] {IDLE, FETCH, DONE} state_t;

    state_t               state, next_state;
    logic [BLOCK_WIDTH:0] issue_cnt, recv_cnt;
    logic                 pending, issue, capture, last, start;
    logic                 unused_offset;

    assign unused_offset = ^missAddrIn[BLOCK_WIDTH-1:0];
    assign start         = state == IDLE && missIn && !flushIn;
    assign memReqOut     = state == FETCH && !issue_cnt[BLOCK_WIDTH] && !flushIn;
    assign issue         = memReqOut && memGrantIn && readyIn;
    assign memAddrOut    = issue ? {memAddr, {BLOCK_WIDTH{1'b0}}} + 32'(issue_cnt) : 32'h0;
    // pending marks a byte issued last cycle whose data is on memByteIn now
    assign capture       = state == FETCH && pending && !flushIn;
    assign last          = capture && recv_cnt == (BLOCK_WIDTH+1)'(BLOCK_SIZE - 1);
    assign memDataValid  = state == DONE && !flushIn;
    assign busy          = state != IDLE;

    always_comb begin
        next_state = flushIn ? IDLE :
                     start ? FETCH :
                     last ? DONE :
                     state == DONE ? IDLE : state;
    end

    always_ff @(posedge clkIn or negedge resetIn) begin
        if (!resetIn)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_ff @(posedge clkIn or negedge resetIn) begin
        if (!resetIn) begin
            issue_cnt  <= '0;
            recv_cnt   <= '0;
            pending    <= 1'b0;
            memAddr    <= '0;
            memDataOut <= '0;
        end else if (flushIn || start) begin
            issue_cnt <= '0;
            recv_cnt  <= '0;
            pending   <= 1'b0;
            if (start)
                memAddr <= missAddrIn[31:BLOCK_WIDTH];
        end else begin
            pending <= issue;
            if (issue)
                issue_cnt <= issue_cnt + 1'b1;
            if (capture) begin
                memDataOut[8*recv_cnt[BLOCK_WIDTH-1:0] +: 8] <= memByteIn;
                recv_cnt <= recv_cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_icache_refill.sv
// tb_icache_refill: directed and randomized refill traffic checked every cycle
// against a transaction-level model of the line fill.
module tb_icache_refill;
    logic         clkIn = 0, resetIn = 0, readyIn = 0, flushIn = 0, missIn = 0, memGrantIn = 0;
    logic [31:0]  missAddrIn = 0;
    logic [7:0]   memByteIn = 0;
    logic         memReqOut, memDataValid, busy;
    logic [31:0]  memAddrOut;
    logic [31:4]  memAddr;
    logic [127:0] memDataOut;

    int checks = 0, failures = 0, cyc = 0, n_valid = 0, valid_cyc = 0;
    logic [27:0]  valid_addr = 0;
    logic [127:0] valid_data = 0;

    int          m_phase = 0, m_iss = 0, m_rcv = 0;
    bit          m_inflight = 0, m_hold = 0, resp_valid = 0;
    logic [27:0] m_base = 0;
    logic [31:0] resp_addr = 0;

    icache_refill dut (
        .clkIn(clkIn), .resetIn(resetIn), .readyIn(readyIn), .flushIn(flushIn),
        .missIn(missIn), .missAddrIn(missAddrIn), .memReqOut(memReqOut),
        .memGrantIn(memGrantIn), .memAddrOut(memAddrOut), .memByteIn(memByteIn),
        .memDataValid(memDataValid), .memAddr(memAddr), .memDataOut(memDataOut), .busy(busy)
    );

    always #5 clkIn = ~clkIn;
    always @(posedge clkIn) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // RAM contents as a pure function of the byte address
    function automatic logic [7:0] ram(input logic [31:0] a);
        return a[7:0] ^ a[23:16];
    endfunction

    function automatic logic [127:0] line_of(input logic [27:0] b);
        logic [127:0] l;
        for (int i = 0; i < 16; i++) l[8*i +: 8] = ram({b, 4'h0} + 32'(i));
        return l;
    endfunction

    // Model: a refill is idle (0), fetching (1) or delivering (2); bytes are issued in
    // address order and each arrives one cycle after its issue.
    always @(negedge clkIn) begin
        bit exp_req, issue_now, exp_valid;
        logic [31:0] exp_maddr;
        if (!resetIn) begin
            m_phase = 0; m_hold = 0; m_inflight = 0; resp_valid = 0;
        end else begin
            exp_req   = m_phase == 1 && m_iss < 16 && !flushIn;
            issue_now = exp_req && memGrantIn && readyIn;
            exp_maddr = issue_now ? {m_base, 4'h0} + 32'(m_iss) : 32'h0;
            exp_valid = m_phase == 2 && !flushIn;
            check("busy", busy, m_phase != 0);
            check("memReqOut", memReqOut, exp_req);
            check("memAddrOut", memAddrOut, exp_maddr);
            check("memDataValid", memDataValid, exp_valid);
            if (m_phase != 0 || m_hold) check("memAddr", memAddr, m_base);
            if (exp_valid || (m_phase == 0 && m_hold)) check("memDataOut", memDataOut, line_of(m_base));
            if (memDataValid) begin
                n_valid++; valid_cyc = cyc; valid_addr = memAddr; valid_data = memDataOut;
            end
            resp_valid = issue_now;
            resp_addr  = exp_maddr;
            if (flushIn) begin
                m_phase = 0; m_inflight = 0;
            end else if (m_phase == 0) begin
                if (missIn) begin
                    m_phase = 1; m_base = missAddrIn[31:4]; m_iss = 0; m_rcv = 0;
                    m_inflight = 0; m_hold = 0;
                end
            end else if (m_phase == 2) begin
                m_phase = 0; m_hold = 1;
            end else begin
                if (m_inflight) m_rcv++;
                m_inflight = issue_now;
                if (issue_now) m_iss++;
                if (m_rcv == 16) m_phase = 2;
            end
        end
    end

    task automatic tick();
        @(posedge clkIn);
        #1;
        memByteIn = resp_valid ? ram(resp_addr) : 8'($urandom);
    endtask

    task automatic start_miss(input logic [31:0] a, output int e0);
        missIn = 1; missAddrIn = a;
        tick();
        e0 = cyc; missIn = 0;
    endtask

    task automatic wait_valid(input int target);
        int b = 0;
        while (n_valid < target && b < 200) begin tick(); b++; end
        check("valid_seen", n_valid >= target, 1'b1);
    endtask

    initial begin
        int e0, nv, first_cyc;
        repeat (3) tick();
        check("rst_req", memReqOut, 0);
        check("rst_maddr", memAddrOut, 0);
        check("rst_valid", memDataValid, 0);
        check("rst_addr", memAddr, 0);
        check("rst_data", memDataOut, 0);
        check("rst_busy", busy, 0);
        resetIn = 1; readyIn = 1; memGrantIn = 1;
        repeat (2) tick();

        // full-grant fill of 0x1234
        nv = n_valid;
        start_miss(32'h0000_1234, e0);
        for (int k = 0; k < 16; k++) begin
            check("full_issue_addr", memAddrOut, 32'h1230 + k);
            tick();
        end
        wait_valid(nv + 1);
        check("full_latency", valid_cyc - e0, 17);
        check("full_line_addr", valid_addr, 28'h000_0123);
        check("full_line_data", valid_data, 128'h3F3E3D3C3B3A39383736353433323130);
        tick();
        check("hold_data", memDataOut, 128'h3F3E3D3C3B3A39383736353433323130);

        // grant gap after byte 5
        nv = n_valid;
        start_miss(32'h0000_8A40, e0);
        while (n_valid < nv + 1 && cyc < e0 + 200) begin
            memGrantIn = !(cyc >= e0 + 6 && cyc <= e0 + 8);
            tick();
        end
        memGrantIn = 1;
        check("gap_latency", valid_cyc - e0, 20);

        // readyIn low two cycles
        nv = n_valid;
        start_miss(32'h0000_3C70, e0);
        while (n_valid < nv + 1 && cyc < e0 + 200) begin
            readyIn = !(cyc >= e0 + 6 && cyc <= e0 + 7);
            tick();
        end
        readyIn = 1;
        check("ready_latency", valid_cyc - e0, 19);

        // flush after 7 bytes captured
        nv = n_valid;
        start_miss(32'h0000_9990, e0);
        repeat (8) tick();
        flushIn = 1;
        #1;
        check("flush_req", memReqOut, 0);
        tick();
        flushIn = 0;
        check("flush_idle", busy, 0);
        repeat (25) tick();
        check("flush_no_valid", n_valid, nv);
        start_miss(32'h0000_5678, e0);
        check("restart_offset0", memAddrOut, 32'h5670);
        wait_valid(nv + 1);

        // asynchronous reset mid-fetch
        nv = n_valid;
        start_miss(32'h0031_4150, e0);
        repeat (5) tick();
        #2 resetIn = 0;
        #1;
        check("arst_req", memReqOut, 0);
        check("arst_maddr", memAddrOut, 0);
        check("arst_valid", memDataValid, 0);
        check("arst_addr", memAddr, 0);
        check("arst_data", memDataOut, 0);
        check("arst_busy", busy, 0);
        repeat (2) tick();
        resetIn = 1;
        repeat (25) tick();
        check("arst_stay_idle", busy, 0);
        check("arst_no_valid", n_valid, nv);

        // back-to-back misses with missIn held high
        nv = n_valid;
        missAddrIn = 32'h100; missIn = 1;
        tick();
        wait_valid(nv + 1);
        first_cyc = valid_cyc;
        check("b2b_first_addr", valid_addr, 28'h010);
        missAddrIn = 32'h200;
        tick();
        missIn = 0;
        wait_valid(nv + 2);
        check("b2b_second_addr", valid_addr, 28'h020);
        check("b2b_spacing", valid_cyc - first_cyc, 19);

        // randomized traffic
        nv = n_valid;
        for (int i = 0; i < 4000; i++) begin
            missIn     = $urandom_range(0, 3) == 0;
            missAddrIn = $urandom;
            memGrantIn = $urandom_range(0, 3) != 0;
            readyIn    = $urandom_range(0, 9) != 0;
            flushIn    = $urandom_range(0, 59) == 0;
            tick();
        end
        missIn = 0; flushIn = 0; memGrantIn = 1; readyIn = 1;
        repeat (40) tick();
        check("random_fills", n_valid > nv + 20, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
